// File: rtl/eq_pkg.sv
// Shared types and sizing helpers for the EQ gain loader slice.
package eq_pkg;

  localparam int GAIN_W    = 16;
  localparam int MAX_GAINS = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_PTR_RST,
    ST_PTR_CHK,
    ST_WRITE,
    ST_GAP,
    ST_DONE
  } eq_state_e;

  // Byte pointer spans 0..2*num_gains inclusive, so it needs one extra code.
  function automatic int ptr_width(input int num_gains);
    return $clog2(2 * num_gains + 1);
  endfunction

  function automatic int idx_width(input int num_gains);
    return (num_gains > 1) ? $clog2(num_gains) : 1;
  endfunction

endpackage

// File: rtl/eq_gain_stage.sv
// CPU-side staging bank: assembles LSB/MSB byte pairs into 16-bit gains and
// owns the sticky load_err flag.
module eq_gain_stage
  import eq_pkg::*;
#(
  parameter int NUM_GAINS = 4,
  localparam int PTR_W = ptr_width(NUM_GAINS),
  localparam int IDX_W = idx_width(NUM_GAINS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_start,
  input  logic              byte_wr,
  input  logic [7:0]        byte_data,
  input  logic              busy,
  input  logic              err_set,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [GAIN_W-1:0] rd_gain,
  output logic              full,
  output logic              load_err
);

  localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(2 * NUM_GAINS);

  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-2:0]  wr_gain;
  logic              accept;
  logic [GAIN_W-1:0] bank [NUM_GAINS];

  assign wr_gain = ptr[PTR_W-1:1];
  assign full    = (ptr == PTR_FULL);
  // Start beats a same-cycle byte; everything is frozen while a commit runs.
  assign accept  = byte_wr && !busy && !load_start && !full;

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) begin
      ptr      <= '0;
      load_err <= 1'b0;
    end else begin
      if (load_start && !busy) begin
        ptr      <= '0;
        load_err <= 1'b0;
      end else if (byte_wr && (busy || full)) begin
        load_err <= 1'b1;
      end else if (accept) begin
        ptr <= ptr + PTR_W'(1);
      end
      if (err_set) load_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: the bank is reset on purpose (it must read back as zero), so it stays in flops, not RAM.
    if (!reset_n) begin
      for (int i = 0; i < NUM_GAINS; i++) bank[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < NUM_GAINS; i++) begin
        if (wr_gain == (PTR_W-1)'(i)) begin
          if (ptr[0]) bank[i][GAIN_W-1:8] <= byte_data;
          else        bank[i][7:0]        <= byte_data;
        end
      end
    end
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    rd_gain = '0;
    for (int i = 0; i < NUM_GAINS; i++) begin
      if (rd_idx == IDX_W'(i)) rd_gain = bank[i];
    end
  end

endmodule

// File: rtl/eq_gain_loader.sv
// Transfers a staged gain bank into the EQ gain RAM between EQ passes,
// pacing writes two cycles apart to match the RAM pointer advance.
module eq_gain_loader
  import eq_pkg::*;
#(
  parameter int NUM_GAINS = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cpu_load_start,
  input  logic       cpu_byte_wr,
  input  logic [7:0] cpu_byte,
  input  logic       cpu_commit,
  input  logic       eq_run,
  input  logic       eq_data_valid,
  input  logic       wr_addr_zero,
  output logic       eq_wr,
  output logic       eq_wr_rst,
  output logic [7:0] eq_gain_lsb,
  output logic [7:0] eq_gain_msb,
  output logic       busy,
  output logic       commit_done,
  output logic       load_err
);

  localparam int IDX_W = idx_width(NUM_GAINS);

  eq_state_e         state, state_next;
  logic [IDX_W-1:0]  gain_idx;
  logic [GAIN_W-1:0] rd_gain;
  logic              full;
  logic              err_set;
  logic              last_gain;

  assign busy      = (state != ST_IDLE);
  assign last_gain = (gain_idx == IDX_W'(NUM_GAINS - 1));

  eq_gain_stage #(.NUM_GAINS(NUM_GAINS)) u_stage (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_start (cpu_load_start),
    .byte_wr    (cpu_byte_wr),
    .byte_data  (cpu_byte),
    .busy       (busy),
    .err_set    (err_set),
    .rd_idx     (gain_idx),
    .rd_gain    (rd_gain),
    .full       (full),
    .load_err   (load_err)
  );

  always_comb begin
    state_next = state;
    err_set    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (cpu_commit) begin
          if (full) state_next = ST_ARMED;
          else      err_set    = 1'b1;
        end
      end
      ST_ARMED:   if (!eq_run || eq_data_valid) state_next = ST_PTR_RST;
      ST_PTR_RST: state_next = ST_PTR_CHK;
      ST_PTR_CHK: begin
        if (wr_addr_zero) begin
          state_next = ST_WRITE;
        end else begin
          state_next = ST_IDLE;
          err_set    = 1'b1;
        end
      end
      ST_WRITE:   state_next = ST_GAP;
      ST_GAP:     state_next = last_gain ? ST_DONE : ST_WRITE;
      ST_DONE:    state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Strobes are registered decodes of the current state, so each one trails
  // its state by a cycle; the data lanes load in step with eq_wr.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      gain_idx    <= '0;
      eq_wr       <= 1'b0;
      eq_wr_rst   <= 1'b0;
      commit_done <= 1'b0;
      eq_gain_lsb <= '0;
      eq_gain_msb <= '0;
    end else begin
      state       <= state_next;
      eq_wr       <= (state == ST_WRITE);
      eq_wr_rst   <= (state == ST_PTR_RST);
      commit_done <= (state == ST_DONE);
      if (state == ST_PTR_CHK)  gain_idx <= '0;
      else if (state == ST_GAP) gain_idx <= gain_idx + IDX_W'(1);
      if (state == ST_WRITE) begin
        eq_gain_lsb <= rd_gain[7:0];
        eq_gain_msb <= rd_gain[GAIN_W-1:8];
      end
    end
  end

endmodule

// File: tb/tb_eq_gain_loader.sv
// Self-checking bench: byte-array model of the staging bank plus a trace of
// every RAM strobe, compared against the expected commit timeline.
module tb_eq_gain_loader;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cpu_load_start = 1'b0;
  logic       cpu_byte_wr = 1'b0;
  logic [7:0] cpu_byte = '0;
  logic       cpu_commit = 1'b0;
  logic       eq_run = 1'b0;
  logic       eq_data_valid = 1'b0;
  logic       wr_addr_zero = 1'b1;
  logic       eq_wr, eq_wr_rst, busy, commit_done, load_err;
  logic [7:0] eq_gain_lsb, eq_gain_msb;

  always #5 clk = ~clk;

  eq_gain_loader #(.NUM_GAINS(N)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cpu_load_start (cpu_load_start),
    .cpu_byte_wr    (cpu_byte_wr),
    .cpu_byte       (cpu_byte),
    .cpu_commit     (cpu_commit),
    .eq_run         (eq_run),
    .eq_data_valid  (eq_data_valid),
    .wr_addr_zero   (wr_addr_zero),
    .eq_wr          (eq_wr),
    .eq_wr_rst      (eq_wr_rst),
    .eq_gain_lsb    (eq_gain_lsb),
    .eq_gain_msb    (eq_gain_msb),
    .busy           (busy),
    .commit_done    (commit_done),
    .load_err       (load_err)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Trace of RAM-side strobes, tagged with the rising edge that produced them.
  int          wr_cyc[$];
  logic [15:0] wr_val[$];
  int          rst_cyc[$];
  int          done_cyc[$];

  always @(negedge clk) begin
    if (eq_wr) begin
      wr_cyc.push_back(cyc);
      wr_val.push_back({eq_gain_msb, eq_gain_lsb});
    end
    if (eq_wr_rst)   rst_cyc.push_back(cyc);
    if (commit_done) done_cyc.push_back(cyc);
  end

  // Reference model: the staged bytes in arrival order.
  logic [7:0] m_bytes [2*N];
  int         m_ptr = 0;
  bit         m_err = 1'b0;

  function automatic logic [15:0] m_gain(input int i);
    return {m_bytes[2*i+1], m_bytes[2*i]};
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_trace();
    wr_cyc.delete(); wr_val.delete(); rst_cyc.delete(); done_cyc.delete();
  endtask

  task automatic load_start();
    tick(); cpu_load_start = 1'b1;
    tick(); cpu_load_start = 1'b0;
    m_ptr = 0;
    m_err = 1'b0;
  endtask

  task automatic load_byte(input logic [7:0] b);
    tick(); cpu_byte_wr = 1'b1; cpu_byte = b;
    tick(); cpu_byte_wr = 1'b0;
    if (m_ptr == 2*N) m_err = 1'b1;
    else begin
      m_bytes[m_ptr] = b;
      m_ptr++;
    end
  endtask

  task automatic load_random(input int count);
    for (int i = 0; i < count; i++) load_byte(8'($urandom));
  endtask

  task automatic commit(output int k);
    clear_trace();
    tick(); cpu_commit = 1'b1;
    tick(); cpu_commit = 1'b0;
    k = cyc;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_timeout: busy=%b after %0d cycles, required 0", tag, busy, n);
    end
  endtask

  // Expected timeline once eq_wr_rst appears on edge r.
  task automatic verify_commit(input int r, input string tag);
    int got;
    total++;
    got = (rst_cyc.size() > 0) ? rst_cyc[0] : -1;
    if (rst_cyc.size() != 1 || got != r) begin
      bad++;
      $display("FAIL %s_wr_rst: count=%0d first=%0d, required count=1 at %0d", tag, rst_cyc.size(), got, r);
    end
    total++;
    if (wr_cyc.size() != N) begin
      bad++;
      $display("FAIL %s_pulse_count: got %0d, required %0d", tag, wr_cyc.size(), N);
    end
    for (int i = 0; i < N && i < wr_cyc.size(); i++) begin
      total++;
      if (wr_cyc[i] != r + 2 + 2*i || wr_val[i] !== m_gain(i)) begin
        bad++;
        $display("FAIL %s_gain%0d: edge=%0d val=%h, required edge=%0d val=%h",
                 tag, i, wr_cyc[i], wr_val[i], r + 2 + 2*i, m_gain(i));
      end
    end
    total++;
    got = (done_cyc.size() > 0) ? done_cyc[0] : -1;
    if (done_cyc.size() != 1 || got != r + 2 + 2*N) begin
      bad++;
      $display("FAIL %s_done: count=%0d edge=%0d, required count=1 at %0d", tag, done_cyc.size(), got, r + 2 + 2*N);
    end
    total++;
    if (load_err !== m_err) begin
      bad++;
      $display("FAIL %s_load_err: got %b, required %b", tag, load_err, m_err);
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    total++;
    if ({eq_wr, eq_wr_rst, busy, commit_done, load_err, eq_gain_lsb, eq_gain_msb} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: wr=%b rst=%b busy=%b done=%b err=%b gain=%h%h, required all 0",
               eq_wr, eq_wr_rst, busy, commit_done, load_err, eq_gain_msb, eq_gain_lsb);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 2*N; i++) m_bytes[i] = '0;
    repeat (2) tick();
    total++;
    if ({eq_wr, eq_wr_rst, busy, commit_done, load_err} !== '0) begin
      bad++;
      $display("FAIL reset_release: wr=%b rst=%b busy=%b done=%b err=%b, required all 0",
               eq_wr, eq_wr_rst, busy, commit_done, load_err);
    end
  endtask

  task automatic test_fixed_load();
    logic [7:0] pat [8];
    int k;
    pat = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A, 8'hF0, 8'hDE};
    load_start();
    for (int i = 0; i < 8; i++) load_byte(pat[i]);
    commit(k);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL fixed_busy: got %b after commit, required 1", busy);
    end
    wait_idle("fixed");
    tick();
    verify_commit(k + 2, "fixed");
    total++;
    if (wr_val.size() == 4 && (wr_val[0] !== 16'h1234 || wr_val[3] !== 16'hDEF0)) begin
      bad++;
      $display("FAIL fixed_literal: got %h..%h, required 1234..def0", wr_val[0], wr_val[3]);
    end
    total++;
    if ({eq_gain_msb, eq_gain_lsb} !== 16'hDEF0) begin
      bad++;
      $display("FAIL fixed_hold: got %h, required def0", {eq_gain_msb, eq_gain_lsb});
    end
  endtask

  task automatic test_random_loads();
    int k;
    for (int it = 0; it < 3; it++) begin
      load_start();
      load_random(2*N);
      commit(k);
      wait_idle("random");
      tick();
      verify_commit(k + 2, "random");
    end
  endtask

  task automatic test_eq_run_wait();
    int e, k;
    eq_run = 1'b1;
    load_start();
    load_random(2*N);
    commit(k);
    repeat (20) tick();
    total++;
    if (rst_cyc.size() != 0 || wr_cyc.size() != 0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL run_hold: rst=%0d wr=%0d busy=%b, required 0 0 1", rst_cyc.size(), wr_cyc.size(), busy);
    end
    eq_data_valid = 1'b1;
    tick(); eq_data_valid = 1'b0;
    e = cyc;
    wait_idle("run");
    tick();
    verify_commit(e + 1, "run");
    eq_run = 1'b0;
  endtask

  task automatic test_short_load();
    int k;
    load_start();
    load_random(6);
    commit(k);
    repeat (10) tick();
    total++;
    if (load_err !== 1'b1 || wr_cyc.size() != 0 || rst_cyc.size() != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL short_reject: err=%b wr=%0d rst=%0d busy=%b, required 1 0 0 0",
               load_err, wr_cyc.size(), rst_cyc.size(), busy);
    end
    load_start();
    total++;
    if (load_err !== 1'b0) begin
      bad++;
      $display("FAIL short_clear: load_err=%b, required 0", load_err);
    end
  endtask

  task automatic test_overflow();
    int k;
    load_start();
    load_random(2*N + 1);
    total++;
    if (load_err !== m_err) begin
      bad++;
      $display("FAIL overflow_err: got %b, required %b", load_err, m_err);
    end
    commit(k);
    wait_idle("overflow");
    tick();
    verify_commit(k + 2, "overflow");
  endtask

  task automatic test_addr_fail();
    int k;
    load_start();
    load_random(2*N);
    wr_addr_zero = 1'b0;
    commit(k);
    wait_idle("addr");
    tick();
    total++;
    if (load_err !== 1'b1 || wr_cyc.size() != 0 || done_cyc.size() != 0 || rst_cyc.size() != 1) begin
      bad++;
      $display("FAIL addr_abort: err=%b wr=%0d done=%0d rst=%0d, required 1 0 0 1",
               load_err, wr_cyc.size(), done_cyc.size(), rst_cyc.size());
    end
    wr_addr_zero = 1'b1;
  endtask

  task automatic test_back_to_back();
    int k;
    load_start();
    load_random(2*N);
    commit(k);
    repeat (2) tick();
    cpu_byte_wr = 1'b1; cpu_byte = 8'($urandom); cpu_load_start = 1'b1;
    tick();
    cpu_byte_wr = 1'b0; cpu_load_start = 1'b0;
    m_err = 1'b1;
    wait_idle("busy_byte");
    tick();
    verify_commit(k + 2, "busy_byte");
    commit(k);
    wait_idle("recommit");
    tick();
    verify_commit(k + 2, "recommit");
  endtask

  task automatic test_reset_mid();
    int k, n;
    load_start();
    load_random(2*N);
    commit(k);
    n = 0;
    while (wr_cyc.size() < 2 && n < 50) begin
      tick();
      n++;
    end
    total++;
    if (wr_cyc.size() != 2 || eq_wr !== 1'b1) begin
      bad++;
      $display("FAIL midrst_setup: pulses=%0d eq_wr=%b, required 2 and 1", wr_cyc.size(), eq_wr);
    end
    reset_n = 1'b0;
    #1;
    total++;
    if ({eq_wr, eq_wr_rst, busy, commit_done, load_err, eq_gain_lsb, eq_gain_msb} !== '0) begin
      bad++;
      $display("FAIL midrst_async: wr=%b rst=%b busy=%b done=%b err=%b gain=%h%h, required all 0",
               eq_wr, eq_wr_rst, busy, commit_done, load_err, eq_gain_msb, eq_gain_lsb);
    end
    repeat (3) tick();
    reset_n = 1'b1;
    m_ptr = 0;
    m_err = 1'b0;
    repeat (15) tick();
    total++;
    if (wr_cyc.size() != 2 || done_cyc.size() != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL midrst_quiet: pulses=%0d done=%0d busy=%b, required 2 0 0",
               wr_cyc.size(), done_cyc.size(), busy);
    end
    commit(k);
    repeat (6) tick();
    total++;
    if (load_err !== 1'b1 || rst_cyc.size() != 0) begin
      bad++;
      $display("FAIL midrst_ptr_cleared: err=%b rst=%0d, required 1 0", load_err, rst_cyc.size());
    end
  endtask

  initial begin
    test_reset();
    test_fixed_load();
    test_random_loads();
    test_eq_run_wait();
    test_short_load();
    test_overflow();
    test_addr_fail();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

endmodule
